// File: rtl/seed_collector.sv
// Collects AES results for a batch of parent seeds and queues the derived child
// seeds (EXPAND: two per parent, HASH: one per parent) in a small FIFO.
module seed_collector #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             func,
  input  logic             start,
  input  logic [CNT_W-1:0] batch_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     parent_seed,
  input  logic [127:0]     left_ct,
  input  logic [127:0]     right_ct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_seed,
  output logic             out_side,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             func_q, func_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Each entry is {side, seed}.
  logic [128:0]     mem_q [DEPTH];

  logic [CW-1:0]    free_entries;
  logic [CW-1:0]    need_entries;
  logic             accept;
  logic             pop;
  logic [1:0]       n_push;
  logic [128:0]     head;

  // Handshakes: a transfer happens on a port in any cycle where valid and ready
  // are both high; ready never depends on valid on the same port.
  always_comb begin
    free_entries = CW'(DEPTH) - count_q;
    need_entries = func_q ? CW'(1) : CW'(2);
    in_ready     = (state_q == S_RUN) && (free_entries >= need_entries) && (acc_q != len_q);
    accept       = in_valid && in_ready;
    out_valid    = (count_q != '0);
    pop          = out_valid && out_ready;
    n_push       = accept ? (func_q ? 2'd1 : 2'd2) : 2'd0;
    head         = mem_q[rd_ptr_q];
    out_seed     = out_valid ? head[127:0] : '0;
    out_side     = out_valid & head[128];
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    dbg_state    = state_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(n_push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(n_push) - CW'(pop);
  end

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    len_d   = len_q;
    acc_d   = acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          func_d  = func;
          len_d   = batch_len;
          acc_d   = '0;
          state_d = (batch_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          acc_d = acc_q + CNT_W'(1);
          if (acc_q + CNT_W'(1) == len_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // A pop of the last entry finishes the drain on the same edge.
        if ((count_q == '0) || ((count_q == CW'(1)) && pop)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      func_q   <= 1'b0;
      len_q    <= '0;
      acc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates everything that reads it.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      if (func_q) begin
        mem_q[wr_ptr_q] <= {1'b0, parent_seed ^ left_ct ^ right_ct};
      end else begin
        mem_q[wr_ptr_q]           <= {1'b0, parent_seed ^ left_ct};
        mem_q[wr_ptr_q + AW'(1)]  <= {1'b1, parent_seed ^ right_ct};
      end
    end
  end

endmodule

// File: tb/tb_seed_collector.sv
// Directed bench for seed_collector: one task per scenario, inline checks.
module tb_seed_collector;

  logic         clk;
  logic         rst;
  logic         func;
  logic         start;
  logic [15:0]  batch_len;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] parent_seed;
  logic [127:0] left_ct;
  logic [127:0] right_ct;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_seed;
  logic         out_side;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  int unsigned errors;
  int unsigned checks;

  seed_collector #(.DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .func(func), .start(start), .batch_len(batch_len),
    .in_valid(in_valid), .in_ready(in_ready), .parent_seed(parent_seed),
    .left_ct(left_ct), .right_ct(right_ct), .out_valid(out_valid),
    .out_ready(out_ready), .out_seed(out_seed), .out_side(out_side),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic f, input logic [15:0] len);
    func = f; batch_len = len; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (out_side !== 1'b0) begin errors++; $display("FAIL reset_out_side: got %b want 0", out_side); end
    checks++; if (out_seed !== 128'h0) begin errors++; $display("FAIL reset_out_seed: got %h want 0", out_seed); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_expand_single();
    out_ready = 1'b1;
    do_start(1'b0, 16'd1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL exp_in_ready: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exp_busy: got %b want 1", busy); end
    parent_seed = 128'h0; left_ct = 128'hA; right_ct = 128'hB; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_seed !== 128'hA || out_side !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL exp_first: got v=%b %h/%b want v=1 a/0", out_valid, out_seed, out_side); end
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL exp_drain_state: got %0d want 2", dbg_state); end
    step();
    checks++; if (out_seed !== 128'hB || out_side !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL exp_second: got v=%b %h/%b want v=1 b/1", out_valid, out_seed, out_side); end
    step();
    checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL exp_done: got done=%b v=%b want done=1 v=0", done, out_valid); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL exp_idle: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_hash();
    logic [127:0] p [3];
    logic [127:0] l [3];
    logic [127:0] r [3];
    logic [127:0] e [3];
    p[0] = 128'h0F0;  l[0] = 128'h00F;  r[0] = 128'hF00;  e[0] = 128'hFFF;
    p[1] = 128'h1234; l[1] = 128'h1200; r[1] = 128'h0001; e[1] = 128'h0035;
    p[2] = 128'h8000_0000_0000_0000_0000_0000_0000_0000; l[2] = 128'h1; r[2] = 128'h100;
    e[2] = 128'h8000_0000_0000_0000_0000_0000_0000_0101;
    out_ready = 1'b1;
    do_start(1'b1, 16'd3);
    for (int i = 0; i < 3; i++) begin
      parent_seed = p[i]; left_ct = l[i]; right_ct = r[i]; in_valid = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1 || out_seed !== e[i] || out_side !== 1'b0) begin
        errors++; $display("FAIL hash_out%0d: got v=%b %h/%b want v=1 %h/0", i, out_valid, out_seed, out_side, e[i]); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL hash_done: got done=%b v=%b want done=1 v=0", done, out_valid); end
    step();
  endtask

  task automatic test_backpressure();
    logic [127:0] e [8];
    e[0] = 128'h101; e[1] = 128'h102; e[2] = 128'h201; e[3] = 128'h202;
    e[4] = 128'h301; e[5] = 128'h302; e[6] = 128'h401; e[7] = 128'h402;
    out_ready = 1'b0;
    do_start(1'b0, 16'd5);
    left_ct = 128'h1; right_ct = 128'h2; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      parent_seed = 128'h100 * (i + 1);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready%0d: got %b want 1", i, in_ready); end
      step();
    end
    parent_seed = 128'h500;
    checks++; if (in_ready !== 1'b0 || dbg_state !== 2'd1) begin
      errors++; $display("FAIL bp_full: got rdy=%b st=%0d want rdy=0 st=1", in_ready, dbg_state); end
    step(); step();
    checks++; if (in_ready !== 1'b0 || out_seed !== 128'h101 || out_side !== 1'b0) begin
      errors++; $display("FAIL bp_hold: got rdy=%b %h/%b want rdy=0 101/0", in_ready, out_seed, out_side); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      checks++; if (out_valid !== 1'b1 || out_seed !== e[j] || out_side !== j[0]) begin
        errors++; $display("FAIL bp_pop%0d: got v=%b %h/%b want v=1 %h/%b", j, out_valid, out_seed, out_side, e[j], j[0]); end
      step();
    end
    checks++; if (out_valid !== 1'b0 || dbg_state !== 2'd1) begin
      errors++; $display("FAIL bp_empty: got v=%b st=%0d want v=0 st=1", out_valid, dbg_state); end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_seed !== 128'h501 || out_side !== 1'b0) begin
      errors++; $display("FAIL bp_last_l: got %h/%b want 501/0", out_seed, out_side); end
    step();
    checks++; if (out_seed !== 128'h502 || out_side !== 1'b1) begin
      errors++; $display("FAIL bp_last_r: got %h/%b want 502/1", out_seed, out_side); end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", done); end
    step();
  endtask

  task automatic test_zero_len();
    out_ready = 1'b1;
    do_start(1'b0, 16'd0);
    checks++; if (busy !== 1'b1 || done !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL zero_done: got busy=%b done=%b v=%b want 1 1 0", busy, done, out_valid); end
    step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL zero_idle: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_reset_midbatch();
    out_ready = 1'b0;
    parent_seed = 128'h77; left_ct = 128'h0; right_ct = 128'h0; in_valid = 1'b1;
    step(); step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL idle_ignore: got v=%b rdy=%b want 0 0", out_valid, in_ready); end
    in_valid = 1'b0;
    do_start(1'b1, 16'd8);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      parent_seed = 128'h10 + 128'(i);
      step();
    end
    in_valid = 1'b0;
    do_start(1'b0, 16'd0);
    checks++; if (dbg_state !== 2'd1 || out_valid !== 1'b1 || out_seed !== 128'h10) begin
      errors++; $display("FAIL run_start_ignored: got st=%0d v=%b %h want st=1 v=1 10", dbg_state, out_valid, out_seed); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || dbg_state !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got v=%b st=%0d busy=%b want 0 0 0", out_valid, dbg_state, busy); end
    out_ready = 1'b1;
    do_start(1'b1, 16'd1);
    parent_seed = 128'h5; left_ct = 128'h3; right_ct = 128'h0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_seed !== 128'h6 || out_side !== 1'b0) begin
      errors++; $display("FAIL post_reset_out: got v=%b %h/%b want v=1 6/0", out_valid, out_seed, out_side); end
    step();
    checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_done: got done=%b v=%b want 1 0", done, out_valid); end
    step();
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; func = 1'b0; start = 1'b0; batch_len = '0; in_valid = 1'b0;
    parent_seed = '0; left_ct = '0; right_ct = '0; out_ready = 1'b0;
    test_reset();
    test_expand_single();
    test_hash();
    test_backpressure();
    test_zero_len();
    test_reset_midbatch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
